// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch-entry type, width defaults and sizing helper
package fetch_queue_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000000;

  // Decode reuses this as its own input record.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] pc;
    logic [DATA_WIDTH_DEF-1:0] instr;
  } fetch_entry_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_ctrl.sv
// rtl/fetch_queue_ctrl.sv - pointers, occupancy and handshake generation for fetch_queue
module fetch_queue_ctrl
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = count_width(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InValid,
  input  logic          OutReady,
  input  logic          Flush,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] Count,
  output logic          InReady,
  output logic          OutValid,
  output logic          wr_en
);

  logic push;
  logic pop;

  // No fall-through: a full queue refuses even when the head leaves this cycle.
  assign InReady  = (Count != CW'(DEPTH)) & Reset;
  assign OutValid = (Count != '0);
  assign push     = InValid & InReady;
  assign pop      = OutValid & OutReady;
  assign wr_en    = push & ~Flush;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      Count <= Count + CW'(1);
      else if (pop && !push) Count <= Count - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {PC, instruction} buffer between instruction memory and decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       InValid,
  input  logic [ADDR_WIDTH-1:0]      InPC,
  input  logic [DATA_WIDTH-1:0]      InInstruction,
  output logic                       InReady,
  output logic                       OutValid,
  output logic [ADDR_WIDTH-1:0]      OutPC,
  output logic [DATA_WIDTH-1:0]      OutInstruction,
  input  logic                       OutReady,
  input  logic                       Flush,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

  fetch_queue_ctrl #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (PW + 1)
  ) u_ctrl (
    .Clk      (Clk),
    .Reset    (Reset),
    .InValid  (InValid),
    .OutReady (OutReady),
    .Flush    (Flush),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .Count    (Count),
    .InReady  (InReady),
    .OutValid (OutValid),
    .wr_en    (wr_en)
  );

  // Flush leaves storage intact; only reset scrubs it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= DATA_WIDTH'(NOP_INSTR);
      end
    end else if (wr_en) begin
      pc_mem[wr_ptr]    <= InPC;
      instr_mem[wr_ptr] <= InInstruction;
    end
  end

  assign OutPC          = pc_mem[rd_ptr];
  assign OutInstruction = instr_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - table-driven and scoreboard bench for fetch_queue
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        InValid = 1'b0;
  logic [31:0] InPC = '0;
  logic [31:0] InInstruction = '0;
  logic        InReady;
  logic        OutValid;
  logic [31:0] OutPC;
  logic [31:0] OutInstruction;
  logic        OutReady = 1'b0;
  logic        Flush = 1'b0;
  logic [2:0]  Count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rdy;
    logic        fl;
    int          exp_count;
  } vec_t;

  vec_t         vecs[$];
  fetch_entry_t sb[$];

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .InValid        (InValid),
    .InPC           (InPC),
    .InInstruction  (InInstruction),
    .InReady        (InReady),
    .OutValid       (OutValid),
    .OutPC          (OutPC),
    .OutInstruction (OutInstruction),
    .OutReady       (OutReady),
    .Flush          (Flush),
    .Count          (Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc ^ 32'h20080005;
  endfunction

  task automatic add(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                     input logic rdy, input logic fl, input int exp_count);
    vec_t t;
    t.v = v; t.pc = pc; t.instr = instr; t.rdy = rdy; t.fl = fl; t.exp_count = exp_count;
    vecs.push_back(t);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input vec_t t);
    fetch_entry_t e;
    int mcount;
    InValid = t.v; InPC = t.pc; InInstruction = t.instr; OutReady = t.rdy; Flush = t.fl;
    #1;
    mcount = sb.size();
    check("in_ready", 64'(InReady), 64'(mcount != DEPTH));
    check("out_valid", 64'(OutValid), 64'(mcount != 0));
    if (mcount != 0) begin
      check("head_pc", 64'(OutPC), 64'(sb[0].pc));
      check("head_instr", 64'(OutInstruction), 64'(sb[0].instr));
    end
    if (t.fl) begin
      sb.delete();
    end else begin
      if (t.rdy && mcount != 0) void'(sb.pop_front());
      if (t.v && mcount != DEPTH) begin
        e.pc = t.pc; e.instr = t.instr;
        sb.push_back(e);
      end
    end
    @(posedge Clk);
    #1;
    check("count_tbl", 64'(Count), 64'(t.exp_count));
    check("count_model", 64'(Count), 64'(sb.size()));
    @(negedge Clk);
  endtask

  task automatic idle_step();
    vec_t t;
    t.v = 0; t.pc = '0; t.instr = '0; t.rdy = 0; t.fl = 0; t.exp_count = sb.size();
    step(t);
  endtask

  initial begin
    // Reset held with InValid asserted.
    InValid = 1'b1; InPC = 32'h40; InInstruction = 32'h1234;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_in_ready", 64'(InReady), 64'd0);
    check("rst_out_valid", 64'(OutValid), 64'd0);
    check("rst_count", 64'(Count), 64'd0);
    check("rst_out_pc", 64'(OutPC), 64'd0);
    check("rst_out_instr", 64'(OutInstruction), 64'd0);
    @(negedge Clk);
    InValid = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("post_rst_in_ready", 64'(InReady), 64'd1);
    check("post_rst_count", 64'(Count), 64'd0);
    @(negedge Clk);

    // Single push, held three cycles, then consumed.
    add(1, 32'h0, 32'h20080005, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, '0, '0, 0, 0, 1);
    add(0, '0, '0, 1, 0, 0);
    // Fill: PC 16 refused while full, even alongside a pop.
    for (int i = 0; i < 4; i++) add(1, 32'(i * 4), mk_instr(32'(i * 4)), 0, 0, i + 1);
    add(1, 32'd16, mk_instr(32'd16), 0, 0, 4);
    add(1, 32'd16, mk_instr(32'd16), 1, 0, 3);
    add(1, 32'd16, mk_instr(32'd16), 0, 0, 4);
    for (int i = 3; i >= 0; i--) add(0, '0, '0, 1, 0, i);
    // Steady stream at occupancy 2; pointers wrap several times.
    add(1, 32'h100, mk_instr(32'h100), 0, 0, 1);
    add(1, 32'h104, mk_instr(32'h104), 0, 0, 2);
    for (int i = 0; i < 10; i++)
      add(1, 32'h108 + 32'(i * 4), mk_instr(32'h108 + 32'(i * 4)), 1, 0, 2);
    add(0, '0, '0, 1, 0, 1);
    add(0, '0, '0, 1, 0, 0);
    // Flush at occupancy 3 beats a same-cycle push and pop.
    for (int i = 0; i < 3; i++) add(1, 32'h200 + 32'(i * 4), mk_instr(32'h200 + 32'(i * 4)), 0, 0, i + 1);
    add(1, 32'h00400010, 32'hdeadbeef, 1, 1, 0);
    add(1, 32'h00400020, 32'h00400020, 0, 0, 1);
    add(0, '0, '0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Asynchronous reset mid-cycle at occupancy 3.
    vecs.delete();
    for (int i = 0; i < 3; i++) add(1, 32'h300 + 32'(i * 4), mk_instr(32'h300 + 32'(i * 4)), 0, 0, i + 1);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    InValid = 1'b0; OutReady = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    check("async_out_valid", 64'(OutValid), 64'd0);
    check("async_count", 64'(Count), 64'd0);
    check("async_in_ready", 64'(InReady), 64'd0);
    sb.delete();
    @(negedge Clk);
    Reset = 1'b1;
    idle_step();
    vecs.delete();
    add(1, 32'h500, mk_instr(32'h500), 0, 0, 1);
    add(1, 32'h504, mk_instr(32'h504), 1, 0, 1);
    add(0, '0, '0, 1, 0, 0);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
